rng_pool_reader: RTL and testbench

Wishbone read initiator that drains random words from the dual-port random-word RAM and presents them as a valid/ready stream.
- Connects to the RAM's port B, the counterpart to the RNG writer on port A.
- Reads the pool sequentially with wrap-around and buffers words in a small FIFO.
- Optionally requests a fresh RNG rewrite of each consumed address, so no word is ever delivered twice.

---
 rtl/rng_pkg.sv | 19 +
 rtl/rng_rd_fifo.sv | 64 ++++++
 rtl/rng_pool_reader.sv | 166 ++++++++++++++++
 tb/tb_rng_pool_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared definitions for the random-word pool: word/address sizes common to
// the RNG writer (RAM port A) and the pool reader (RAM port B), plus the
// reader state encoding.
package rng_pkg;

    localparam int RNG_WORD_W     = 32;
    localparam int RNG_ADDR_W     = 9;
    localparam int RNG_POOL_WORDS = 512;

    localparam logic [3:0] WB_WE_READ = 4'b0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        REFILL   = 2'd3
    } rd_state_e;

endpackage

// File: rtl/rng_rd_fifo.sv
// Small synchronous FIFO that buffers pool words between the Wishbone read
// side and the output stream. Head word is shown combinationally and reads
// as zero while the FIFO is empty.
module rng_rd_fifo
    import rng_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = RNG_WORD_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == COUNT_FULL);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage array: data only, never reset
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rng_pool_reader.sv
// Wishbone read initiator on RAM port B: walks the random-word pool with
// wrap-around, one read in flight at a time, and presents the words as a
// valid/ready stream through a small FIFO.
// Build option: define RNG_REFILL_EN to request an RNG rewrite of every
// address after it has been read, so no pool word is delivered twice.
module rng_pool_reader
    import rng_pkg::*;
#(
    parameter int ADDR_W     = RNG_ADDR_W,
    parameter int POOL_WORDS = RNG_POOL_WORDS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    output logic                  m_wb_cyc_o,
    output logic                  m_wb_stb_o,
    output logic [3:0]            m_wb_we_o,
    output logic [ADDR_W-1:0]     m_wb_addr_o,
    output logic [31:0]           m_wb_data_o,
    input  logic                  m_wb_ack_i,
    input  logic                  m_wb_stall_i,
    input  logic [31:0]           m_wb_data_i,
    output logic                  rnd_valid_o,
    input  logic                  rnd_ready_i,
    output logic [31:0]           rnd_data_o,
    output logic                  refill_req_o,
    output logic [ADDR_W-1:0]     refill_addr_o,
    input  logic                  refill_ack_i,
    output logic [15:0]           words_out_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FIFO_SLOTS = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(POOL_WORDS - 1);

    rd_state_e             state;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W-1:0]     next_ptr;
    logic                  cyc_q;
    logic                  stb_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  unused_fifo_full;
    logic [15:0]           words_q;

    assign m_wb_cyc_o  = cyc_q;
    assign m_wb_stb_o  = stb_q;
    assign m_wb_addr_o = addr_q;
    assign m_wb_we_o   = WB_WE_READ;
    assign m_wb_data_o = '0;
    assign words_out_o = words_q;

    assign next_ptr = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

    // A read completes on ack either while the strobe is being accepted or afterwards
    assign push = m_wb_ack_i &&
                  (((state == REQ) && !m_wb_stall_i) || (state == WAIT_ACK));

    assign rnd_valid_o = !fifo_empty;
    assign pop         = rnd_valid_o && rnd_ready_i;

    rng_rd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (RNG_WORD_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (m_wb_data_i),
        .pop       (pop),
        .head_data (rnd_data_o),
        .count     (fifo_count),
        .full      (unused_fifo_full),
        .empty     (fifo_empty)
    );

`ifdef RNG_REFILL_EN
    logic              refill_req_q;
    logic [ADDR_W-1:0] last_addr;

    assign refill_req_o  = refill_req_q;
    assign refill_addr_o = last_addr;
`else
    logic unused_refill_ack;

    assign unused_refill_ack = refill_ack_i;
    assign refill_req_o      = 1'b0;
    assign refill_addr_o     = '0;
`endif

    // Read sequencer: one read in flight, a FIFO slot reserved before each strobe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rd_ptr <= '0;
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            addr_q <= '0;
`ifdef RNG_REFILL_EN
            refill_req_q <= 1'b0;
            last_addr    <= '0;
`endif
        end else begin
`ifdef RNG_REFILL_EN
            refill_req_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (enable_i && (fifo_count < FIFO_SLOTS)) begin
                        state  <= REQ;
                        cyc_q  <= 1'b1;
                        stb_q  <= 1'b1;
                        addr_q <= rd_ptr;
                    end
                end
                REQ: begin
                    if (!m_wb_stall_i) begin
                        stb_q <= 1'b0;
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    state <= WAIT_ACK;
                end
`ifdef RNG_REFILL_EN
                REFILL: begin
                    if (refill_ack_i) begin
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase

            // Completion overrides the per-state updates above
            if (push) begin
                cyc_q  <= 1'b0;
                stb_q  <= 1'b0;
                rd_ptr <= next_ptr;
`ifdef RNG_REFILL_EN
                state        <= REFILL;
                refill_req_q <= 1'b1;
                last_addr    <= rd_ptr;
`else
                state <= IDLE;
`endif
            end
        end
    end

    // Stream handshake counter, wraps naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            words_q <= '0;
        end else if (pop) begin
            words_q <= words_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_rng_pool_reader.sv
// Bench for rng_pool_reader: Wishbone slave model with configurable ack
// latency, scoreboard of returned words checked on every stream handshake,
// and a refill responder when built with RNG_REFILL_EN.
`timescale 1ns/1ps
module tb_rng_pool_reader;
    import rng_pkg::*;

    localparam int ADDR_W     = 9;
    localparam int POOL_WORDS = 512;
    localparam int FIFO_DEPTH = 4;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(POOL_WORDS - 1);

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              enable_i = 1'b0;
    logic              m_wb_cyc_o;
    logic              m_wb_stb_o;
    logic [3:0]        m_wb_we_o;
    logic [ADDR_W-1:0] m_wb_addr_o;
    logic [31:0]       m_wb_data_o;
    logic              m_wb_ack_i = 1'b0;
    logic              m_wb_stall_i = 1'b0;
    logic [31:0]       m_wb_data_i = '0;
    logic              rnd_valid_o;
    logic              rnd_ready_i = 1'b1;
    logic [31:0]       rnd_data_o;
    logic              refill_req_o;
    logic [ADDR_W-1:0] refill_addr_o;
    logic              refill_ack_i = 1'b0;
    logic [15:0]       words_out_o;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [31:0]       exp_q[$];
    int                n_accepts = 0;
    int                tb_words = 0;
    int                ack_lat = 1;
    int                n_refills = 0;
    int                n_refill_noise = 0;
    bit                slave_abort = 1'b0;
    bit                force_beef = 1'b0;
    bit                saw_wrap = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [ADDR_W-1:0] last_a = '0;
    logic [15:0]       seq = '0;

    always #5 clk_i = ~clk_i;

    rng_pool_reader #(
        .ADDR_W     (ADDR_W),
        .POOL_WORDS (POOL_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .m_wb_cyc_o    (m_wb_cyc_o),
        .m_wb_stb_o    (m_wb_stb_o),
        .m_wb_we_o     (m_wb_we_o),
        .m_wb_addr_o   (m_wb_addr_o),
        .m_wb_data_o   (m_wb_data_o),
        .m_wb_ack_i    (m_wb_ack_i),
        .m_wb_stall_i  (m_wb_stall_i),
        .m_wb_data_i   (m_wb_data_i),
        .rnd_valid_o   (rnd_valid_o),
        .rnd_ready_i   (rnd_ready_i),
        .rnd_data_o    (rnd_data_o),
        .refill_req_o  (refill_req_o),
        .refill_addr_o (refill_addr_o),
        .refill_ack_i  (refill_ack_i),
        .words_out_o   (words_out_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
        enable_i = 1'b0;
        repeat (40) @(posedge clk_i);
        #1;
    endtask

    // Wishbone slave: sample acceptance mid-cycle, ack after ack_lat cycles
    initial begin : slave
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        forever begin
            @(negedge clk_i);
            if (!rst_i && m_wb_cyc_o && m_wb_stb_o && !m_wb_stall_i) begin
                a = m_wb_addr_o;
                check("rd_addr", 32'(a), 32'(exp_addr));
                if (a == '0 && last_a == LAST_A && n_accepts > 0) saw_wrap = 1'b1;
                last_a   = a;
                exp_addr = (exp_addr == LAST_A) ? '0 : exp_addr + 1'b1;
                n_accepts++;
                repeat (ack_lat) @(posedge clk_i);
                #1;
                if (slave_abort) begin
                    slave_abort = 1'b0;
                end else begin
                    d = force_beef ? 32'hDEADBEEF : {7'h2d, seq, a};
                    force_beef = 1'b0;
                    seq++;
                    exp_q.push_back(d);
                    m_wb_data_i = d;
                    m_wb_ack_i  = 1'b1;
                    @(posedge clk_i);
                    #1;
                    m_wb_ack_i = 1'b0;
                end
            end
        end
    end

    // Stream consumer: scoreboard compare on handshake, stability while stalled
    initial begin : consumer
        logic [31:0] held;
        logic [31:0] e;
        bit          holding;
        holding = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i || !rnd_valid_o) begin
                holding = 1'b0;
            end else if (rnd_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_data", rnd_data_o, e);
                end
                tb_words++;
                holding = 1'b0;
            end else begin
                if (holding) check("hold_stable", rnd_data_o, held);
                held    = rnd_data_o;
                holding = 1'b1;
            end
        end
    end

`ifdef RNG_REFILL_EN
    // Refill responder: ack 5 cycles after the request pulse, no reads meanwhile
    initial begin : refill_resp
        logic [ADDR_W-1:0] ra;
        forever begin
            @(negedge clk_i);
            if (!rst_i && refill_req_o) begin
                ra = refill_addr_o;
                check("refill_addr", 32'(ra), 32'(last_a));
                n_refills++;
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk_i);
                    #1;
                    if (i == 0) check("refill_pulse", 32'(refill_req_o), 32'd0);
                    check("refill_no_cyc", 32'(m_wb_cyc_o), 32'd0);
                    check("refill_addr_hold", 32'(refill_addr_o), 32'(ra));
                end
                refill_ack_i = 1'b1;
                @(posedge clk_i);
                #1;
                refill_ack_i = 1'b0;
            end
        end
    end
`else
    // Refill outputs must stay quiet in the default build
    always @(negedge clk_i) begin
        if (refill_req_o !== 1'b0 || refill_addr_o !== '0) n_refill_noise++;
    end
`endif

    initial begin : main
        int base;
        int k;
        logic [ADDR_W-1:0] a0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_cyc", 32'(m_wb_cyc_o), 32'd0);
        check("rst_stb", 32'(m_wb_stb_o), 32'd0);
        check("rst_addr", 32'(m_wb_addr_o), 32'd0);
        check("rst_valid", 32'(rnd_valid_o), 32'd0);
        check("rst_data", rnd_data_o, 32'd0);
        check("rst_words", 32'(words_out_o), 32'd0);
        check("rst_refill", 32'(refill_req_o), 32'd0);
        check("we_const", 32'(m_wb_we_o), 32'(WB_WE_READ));
        check("wdata_const", m_wb_data_o, 32'd0);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // First read returns DEADBEEF from address 0
        force_beef = 1'b1;
        rnd_ready_i = 1'b1;
        enable_i = 1'b1;
        k = 0;
        while (!rnd_valid_o && k < 50) begin
            if (n_accepts > 0) enable_i = 1'b0;
            @(posedge clk_i);
            #1;
            k++;
        end
        enable_i = 1'b0;
        check("first_valid", 32'(rnd_valid_o), 32'd1);
        check("first_data", rnd_data_o, 32'hDEADBEEF);
        check("first_addr", 32'(last_a), 32'd0);
        settle();
        check("first_words", 32'(words_out_o), 32'd1);

        // Stream stalled: exactly FIFO_DEPTH reads, then one more per pop
        rnd_ready_i = 1'b0;
        base = n_accepts;
        enable_i = 1'b1;
        repeat (120) @(posedge clk_i);
        #1;
        check("fill_reads", 32'(n_accepts - base), 32'(FIFO_DEPTH));
        check("fill_no_stb", 32'(m_wb_stb_o), 32'd0);
        check("fill_valid", 32'(rnd_valid_o), 32'd1);
        rnd_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rnd_ready_i = 1'b0;
        repeat (60) @(posedge clk_i);
        #1;
        check("refill_one_read", 32'(n_accepts - base), 32'(FIFO_DEPTH + 1));
        check("refill_read_addr", 32'(last_a), 32'(FIFO_DEPTH + 1));
        rnd_ready_i = 1'b1;
        settle();
        check("words_after_fill", 32'(words_out_o), 32'(tb_words));

        // Run across the end of the pool and wrap to address 0
        enable_i = 1'b1;
        k = 0;
        while (!saw_wrap && k < 12000) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check("wrap_seen", 32'(saw_wrap), 32'd1);
        settle();
        check("words_after_wrap", 32'(words_out_o), 32'(tb_words & 16'hFFFF));

        // Stall for 3 cycles: strobe and address held, one transfer
        m_wb_stall_i = 1'b1;
        base = n_accepts;
        enable_i = 1'b1;
        k = 0;
        while (!m_wb_stb_o && k < 50) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        enable_i = 1'b0;
        check("stall_stb_seen", 32'(m_wb_stb_o), 32'd1);
        a0 = m_wb_addr_o;
        for (int c = 2; c <= 4; c++) begin
            @(posedge clk_i);
            #1;
            if (c == 4) m_wb_stall_i = 1'b0;
            check("stall_stb_hold", 32'(m_wb_stb_o), 32'd1);
            check("stall_addr_hold", 32'(m_wb_addr_o), 32'(a0));
        end
        @(posedge clk_i);
        #1;
        check("stall_stb_drop", 32'(m_wb_stb_o), 32'd0);
        settle();
        check("stall_one_xfer", 32'(n_accepts - base), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset while waiting for an ack with two words buffered
        rnd_ready_i = 1'b0;
        base = n_accepts;
        enable_i = 1'b1;
        k = 0;
        while (n_accepts < base + 2 && k < 100) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        ack_lat = 6;
        k = 0;
        while (n_accepts < base + 3 && k < 100) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check("rst_setup_reads", 32'(n_accepts - base), 32'd3);
        repeat (2) @(posedge clk_i);
        #1;
        check("pre_rst_cyc", 32'(m_wb_cyc_o), 32'd1);
        check("pre_rst_valid", 32'(rnd_valid_o), 32'd1);
        check("pre_rst_buffered", 32'(exp_q.size()), 32'd2);
        enable_i = 1'b0;
        slave_abort = 1'b1;
        rst_i = 1'b1;
        #1;
        check("async_rst_cyc", 32'(m_wb_cyc_o), 32'd0);
        check("async_rst_stb", 32'(m_wb_stb_o), 32'd0);
        check("async_rst_valid", 32'(rnd_valid_o), 32'd0);
        check("async_rst_words", 32'(words_out_o), 32'd0);
        exp_q.delete();
        exp_addr = '0;
        tb_words = 0;
        ack_lat  = 1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        rnd_ready_i = 1'b1;
        base = n_accepts;
        enable_i = 1'b1;
        k = 0;
        while (n_accepts < base + 1 && k < 50) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check("restart_read", 32'(n_accepts - base), 32'd1);
        check("restart_addr", 32'(last_a), 32'd0);
        settle();
        check("restart_words", 32'(words_out_o), 32'(tb_words));
        check("final_drained", 32'(exp_q.size()), 32'd0);

`ifdef RNG_REFILL_EN
        check("refill_count", 32'(n_refills), 32'(n_accepts - 1));
`else
        check("refill_quiet", 32'(n_refill_noise), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
